// File: rtl/pll_reconfig_pkg.sv
// ---------------------------------------------------------------------------
// pll_reconfig_pkg
// Shared definitions for the PLL reconfiguration scan path: chain length,
// Avalon register map shared with the writer, status bit positions, the
// responder FSM state type and a helper that slices the captured chain into
// the writer's 32-bit register image.
// ---------------------------------------------------------------------------
package pll_reconfig_pkg;

    localparam int unsigned CHAIN_BITS = 144;

    // Register map (word addresses), identical on the writer side
    localparam logic [2:0]  STATUS     = 3'd0;
    localparam logic [2:0]  DATA_START = 3'd1;
    localparam int unsigned DATA_REGS  = 5;

    // Status word bit positions
    localparam int unsigned ST_LOCKED       = 0;
    localparam int unsigned ST_COUNT_ERR    = 1;
    localparam int unsigned ST_BUSY         = 2;
    localparam int unsigned ST_LAST_CNT_LSB = 8;
    localparam int unsigned ST_UPD_CNT_LSB  = 24;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_RECONF
    } state_e;

    // Word idx (0 = first data register) of the register image. The chain is
    // MSB-first across the words; the last word carries 16 chain bits in its
    // upper half and zero padding below.
    function automatic logic [31:0] cfg_word(input logic [CHAIN_BITS-1:0] cfg,
                                             input logic [2:0]            idx);
        logic [CHAIN_BITS+15:0] padded;
        logic [31:0]            w;
        padded = {cfg, 16'h0000};
        w      = '0;
        case (idx)
            3'd0:    w = padded[159:128];
            3'd1:    w = padded[127:96];
            3'd2:    w = padded[95:64];
            3'd3:    w = padded[63:32];
            3'd4:    w = padded[31:0];
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/pll_lock_model.sv
// ---------------------------------------------------------------------------
// pll_lock_model
// Models PLL lock acquisition. While areset is high the PLL is unlocked and
// the lock timer is held at its reload value; once areset falls, locked
// rises LOCK_DLY edges after the first edge that samples areset low.
//
// Ports:
//   clk_i     in  clock
//   rst_ni    in  synchronous active-low reset
//   areset_i  in  PLL reset from the controller
//   locked_o  out modelled lock indication (registered)
// ---------------------------------------------------------------------------
module pll_lock_model #(
    parameter int unsigned LOCK_DLY = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic areset_i,
    output logic locked_o
);

    localparam logic [15:0] RELOAD = 16'(LOCK_DLY - 1);

    logic [15:0] cnt_q;
    logic        areset_q;
    logic        locked_q;

    // The counter is also reloaded on the first edge that samples areset low
    // (areset_q still high), so counting starts on the following edge and the
    // rise lands exactly LOCK_DLY edges after that first low sample. Reset
    // presets areset_q so reset release behaves like an areset fall.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q    <= RELOAD;
            areset_q <= 1'b1;
            locked_q <= 1'b0;
        end else begin
            areset_q <= areset_i;
            if (areset_i || areset_q) begin
                cnt_q <= RELOAD;
                if (areset_i) begin
                    locked_q <= 1'b0;
                end
            end else if (cnt_q == 16'd0) begin
                locked_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - 16'd1;
            end
        end
    end

    assign locked_o = locked_q;

endmodule

// File: rtl/pll_scanchain_responder.sv
// ---------------------------------------------------------------------------
// pll_scanchain_responder
// PLL side of the dynamic-reconfiguration scan interface. Shifts in the
// serial configuration stream, latches it on configupdate, signals scandone
// after a fixed delay and models PLL lock under areset. The captured chain,
// shift count, update count and error/lock/busy status are readable over an
// Avalon-MM slave for end-to-end checking of the reconfiguration path.
//
// Ports:
//   clk_i                   in  clock, also the scan clock
//   rst_ni                  in  synchronous active-low reset
//   avalon_s_writedata      in  write data
//   avalon_s_readdata       out combinational read data (0 when not reading)
//   avalon_s_address        in  word address
//   avalon_s_byteenable     in  byte enables
//   avalon_s_write/read/chipselect in Avalon strobes
//   avalon_s_waitrequest_n  out always 1
//   areset                  in  PLL reset
//   scanclkena              in  shift enable
//   scandata                in  serial data, first bit lands in chain bit 0
//   configupdate            in  apply strobe
//   scandone                out reconfiguration complete (level)
//   locked                  out modelled PLL lock
// ---------------------------------------------------------------------------
module pll_scanchain_responder
    import pll_reconfig_pkg::*;
#(
    parameter int unsigned SCANDONE_DLY = 16,
    parameter int unsigned LOCK_DLY     = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] avalon_s_writedata,
    output logic [31:0] avalon_s_readdata,
    input  logic [2:0]  avalon_s_address,
    input  logic [3:0]  avalon_s_byteenable,
    input  logic        avalon_s_write,
    input  logic        avalon_s_read,
    input  logic        avalon_s_chipselect,
    output logic        avalon_s_waitrequest_n,
    input  logic        areset,
    input  logic        scanclkena,
    input  logic        scandata,
    input  logic        configupdate,
    output logic        scandone,
    output logic        locked
);

    localparam logic [7:0] CHAIN_CNT = 8'(CHAIN_BITS);
    localparam logic [7:0] DONE_LOAD = 8'(SCANDONE_DLY - 1);

    state_e                state_q;
    logic [CHAIN_BITS-1:0] sr_q;
    logic [CHAIN_BITS-1:0] active_cfg_q;
    logic [7:0]            bitcnt_q;
    logic [7:0]            last_cnt_q;
    logic [7:0]            upd_cnt_q;
    logic [7:0]            dly_q;
    logic                  scandone_q;
    logic                  count_err_q;
    logic                  count_err_d;
    logic                  err_set;
    logic                  err_clr;
    logic                  lock_w;
    logic [31:0]           status_w;
    logic [31:0]           rdata_w;
    logic [2:0]            word_idx;
    logic                  unused_ok;

    // -----------------------------------------------------------------------
    // Lock model
    // -----------------------------------------------------------------------
    pll_lock_model #(
        .LOCK_DLY (LOCK_DLY)
    ) u_lock (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .areset_i (areset),
        .locked_o (lock_w)
    );

    // -----------------------------------------------------------------------
    // Sticky protocol error: update outside a shift sequence, wrong bit count
    // at update, or any strobe while the reconfiguration is in progress.
    // A set in the same cycle as a software clear wins.
    // -----------------------------------------------------------------------
    always_comb begin
        err_set = 1'b0;
        case (state_q)
            S_IDLE:   err_set = configupdate;
            S_SHIFT:  err_set = configupdate && (bitcnt_q != CHAIN_CNT);
            S_RECONF: err_set = configupdate || scanclkena;
            default:  err_set = 1'b0;
        endcase
    end

    assign err_clr = avalon_s_chipselect && avalon_s_write &&
                     (avalon_s_address == STATUS) &&
                     avalon_s_byteenable[0] && avalon_s_writedata[1];

    assign count_err_d = err_set | (count_err_q & ~err_clr);

    // -----------------------------------------------------------------------
    // Scan FSM. configupdate has priority over scanclkena, so a bit presented
    // together with the update is neither shifted nor counted.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            sr_q         <= '0;
            active_cfg_q <= '0;
            bitcnt_q     <= '0;
            last_cnt_q   <= '0;
            upd_cnt_q    <= '0;
            dly_q        <= '0;
            scandone_q   <= 1'b0;
            count_err_q  <= 1'b0;
        end else begin
            count_err_q <= count_err_d;
            case (state_q)
                S_IDLE: begin
                    if (!configupdate && scanclkena) begin
                        sr_q       <= {scandata, sr_q[CHAIN_BITS-1:1]};
                        bitcnt_q   <= 8'd1;
                        scandone_q <= 1'b0;
                        state_q    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (configupdate) begin
                        active_cfg_q <= sr_q;
                        last_cnt_q   <= bitcnt_q;
                        dly_q        <= DONE_LOAD;
                        state_q      <= S_RECONF;
                    end else if (scanclkena) begin
                        sr_q <= {scandata, sr_q[CHAIN_BITS-1:1]};
                        if (bitcnt_q != 8'hFF) begin
                            bitcnt_q <= bitcnt_q + 8'd1;
                        end
                    end
                end
                S_RECONF: begin
                    if (dly_q == 8'd0) begin
                        scandone_q <= 1'b1;
                        upd_cnt_q  <= upd_cnt_q + 8'd1;
                        state_q    <= S_IDLE;
                    end else begin
                        dly_q <= dly_q - 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Avalon read path (combinational)
    // -----------------------------------------------------------------------
    always_comb begin
        status_w                            = '0;
        status_w[ST_LOCKED]                 = lock_w;
        status_w[ST_COUNT_ERR]              = count_err_q;
        status_w[ST_BUSY]                   = (state_q != S_IDLE);
        status_w[ST_LAST_CNT_LSB +: 8]      = last_cnt_q;
        status_w[ST_UPD_CNT_LSB +: 8]       = upd_cnt_q;
    end

    assign word_idx = avalon_s_address - DATA_START;

    always_comb begin
        rdata_w = '0;
        if (avalon_s_chipselect && avalon_s_read) begin
            if (avalon_s_address == STATUS) begin
                rdata_w = status_w;
            end else if (word_idx < 3'(DATA_REGS)) begin
                rdata_w = cfg_word(active_cfg_q, word_idx);
            end
        end
    end

    assign avalon_s_readdata      = rdata_w;
    assign avalon_s_waitrequest_n = 1'b1;
    assign scandone               = scandone_q;
    assign locked                 = lock_w;

    // Write data and byte lanes beyond the clear bit carry no function.
    assign unused_ok = ^{avalon_s_byteenable[3:1], avalon_s_writedata[31:2],
                         avalon_s_writedata[0]};

endmodule

// File: doc/pll_scanchain_responder.md
# pll_scanchain_responder

Responder end of the PLL dynamic-reconfiguration scan interface: models the PLL side of the chain for simulation and for on-chip loopback/readback. Captures the serial config stream (scanclkena/scandata), applies it on configupdate, reports completion on scandone, and models lock behaviour under areset. Captured configuration and status are exposed to the Nios over an Avalon-MM slave so that the reconfiguration path can be checked end to end.

## Interface
- CHAIN_BITS, 144, scan chain length in bits.
- SCANDONE_DLY, 16, clk_i cycles from configupdate to scandone assertion (1..255).
- LOCK_DLY, 64, clk_i cycles from areset deassertion to locked (1..65535).
- clk_i  in  1  clock; also the scan clock, with one bit shifted per enabled cycle.
- rst_ni  in  1  synchronous active-low reset.
- avalon_s_writedata  in  32  write data.
- avalon_s_readdata  out  32  read data.
- avalon_s_address  in  3  word address.
- avalon_s_byteenable  in  4  byte enables.
- avalon_s_write, avalon_s_read, avalon_s_chipselect  in  1 each  Avalon strobes.
- avalon_s_waitrequest_n  out  1  tied 1.
- areset  in  1  PLL reset from the controller.
- scanclkena  in  1  shift enable.
- scandata  in  1  serial data, first bit = chain bit 0.
- configupdate  in  1  apply strobe.
- scandone  out  1  reconfiguration complete (level).
- locked  out  1  modelled PLL lock.

## Operation
- Shift register sr[CHAIN_BITS-1:0]: on an enabled cycle, sr <= {scandata, sr[CHAIN_BITS-1:1]}. After 144 shifts, the first bit received is in sr[0].
- bitcnt: 8 bits, cleared on the first shift of a sequence, +1 per shift, saturates at 255.
- FSM states:
  - IDLE: first scanclkena -> SHIFT; scandone <= 0 in the same edge.
  - SHIFT: configupdate -> RECONF; active_cfg <= sr; last_cnt <= bitcnt; count_err |= (bitcnt != CHAIN_BITS); dly <= SCANDONE_DLY-1.
  - RECONF: dly decrements; at 0 -> IDLE with scandone <= 1, upd_cnt +1 (8 bits, wraps).
- configupdate while in IDLE -> IDLE is kept, active_cfg is unchanged, count_err <= 1.
- Priority: configupdate and scanclkena in the same cycle: update wins, that bit is dropped and not counted.
- scanclkena or configupdate while in RECONF: ignored; count_err <= 1.
- Lock model: areset=1 -> locked <= 0 and lock counter reloaded with LOCK_DLY-1. After areset falls, locked <= 1 once the counter reaches 0. areset has no effect on FSM state or on active_cfg.
- Register map:
  - addr 0 read: {upd_cnt[31:24], 8'h0, last_cnt[15:8], 5'h0, busy[2], count_err[1], locked[0]}. busy = state != IDLE.
  - addr 0 write: byteenable[0] && writedata[1] clears count_err. A set in the same cycle wins over the clear.
  - addr 1: active_cfg[143:112]; addr 2: [111:80]; addr 3: [79:48]; addr 4: [47:16]; addr 5: {active_cfg[15:0],16'h0}; addr 6,7: 0.
  - This map matches the writer's register image, so a write-then-readback round trip returns identical words. The low 16 bits of addr 5 are not part of the chain and read 0.
- Reads are combinational: readdata = selected word when chipselect&&read, else 0.

## Timing
- Reset values: scandone=0, locked=0, readdata=0, state=IDLE, all counters, sr, active_cfg and count_err = 0. The lock counter resets to LOCK_DLY-1, so locked rises LOCK_DLY cycles after reset release if areset=0.
- Shift latency: scandata sampled on the same edge as scanclkena=1.
- scandone: rises exactly SCANDONE_DLY edges after the edge that samples configupdate. Falls on the edge that samples the first scanclkena of the next sequence.
- locked: rises LOCK_DLY edges after the first edge sampling areset=0. Falls on the edge sampling areset=1.
- Reset mid-shift or mid-RECONF: everything returns to reset values on that edge and the partial stream is discarded.

## Structure
- A shared package pll_reconfig_pkg holds:
  - CHAIN_BITS;
  - the register address constants (STATUS=0, DATA_START=1, DATA_REGS=5), also used by the writer;
  - the status bit indices;
  - the FSM state enum.
- One sub-module, pll_lock_model: areset in, locked out, LOCK_DLY counter. Everything else stays in a single module.

## Test plan
- Reset, then 144 shifts of the pattern corresponding to writer words addr1..5 = 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 32'h1234_0000, then configupdate. Required response:
  - addr1..5 read back exactly those words;
  - status last_cnt = 144 (0x90), count_err = 0;
  - scandone rises 16 cycles after configupdate;
  - upd_cnt = 1.
- 143 shifts then configupdate -> count_err=1, last_cnt=143. Write 0x2 to addr 0 -> count_err=0.
- configupdate and scanclkena in the same cycle after 144 shifts -> that bit is dropped, last_cnt=144, data is unchanged vs the 144-bit case.
- scanclkena pulse during RECONF -> ignored and count_err=1. scandone still rises on schedule.
- areset high 5 cycles, then low -> locked drops on the next edge and rises 64 cycles after areset falls. active_cfg is unchanged.
- rst_ni low mid-shift (after 70 bits) -> scandone=0, locked=0, addr1..5 read 0. A full subsequent 144-bit load then succeeds.
